// File: rtl/config_fsm_param.sv
//------------------------------------------------------------------------------
// Module  : config_fsm_param
// Purpose : Configuration frame sequencer: sync hunt, header capture, row walk,
//           stretched frame commit strobe, frame counter and header-error flag.
//           Optional idle watchdog enabled by CONFIG_FSM_PARAM_WATCHDOG_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module config_fsm_param #(
    parameter int          NumberOfRows    = 10,
    parameter int          RowSelectWidth  = 5,
    parameter int          FrameBitsPerRow = 32,
    parameter int          DataWidth       = 32,
    parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1,
    parameter int          DesyncFlag      = 20,
    parameter int          StrobeLength    = 2,
    parameter int          FrameCountWidth = 16
`ifdef CONFIG_FSM_PARAM_WATCHDOG_EN
    ,
    parameter int          WatchdogCycles  = 1024
`endif
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic [DataWidth-1:0]       WriteData,
    input  logic                       WriteStrobe,
    output logic [FrameBitsPerRow-1:0] FrameAddressRegister,
    output logic                       LongFrameStrobe,
    output logic [RowSelectWidth-1:0]  RowSelect,
    output logic                       Synced,
    output logic [FrameCountWidth-1:0] FrameCount,
    output logic                       HeaderError,
    output logic                       WatchdogTrip
);

    typedef enum logic [1:0] {
        ST_UNSYNC = 2'd0,
        ST_SYNCED = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

    localparam logic [DataWidth-1:0]      SYNC_PATTERN = DataWidth'(SyncWord);
    localparam logic [RowSelectWidth-1:0] ROWS_LOAD    = RowSelectWidth'(NumberOfRows);
    localparam logic [RowSelectWidth-1:0] ROW_LAST     = RowSelectWidth'(1);
    localparam logic [3:0]                STROBE_LOAD  = 4'(StrobeLength);

    state_t                    state;
    logic [RowSelectWidth-1:0] row_cnt;
    logic                      commit;
    logic [3:0]                strobe_cnt;
    logic [7:0]                hdr_rows;
    logic                      hdr_rows_bad;
    logic                      wd_fire;

    // The header row field is advisory only; frame length is always NumberOfRows.
    assign hdr_rows     = WriteData[DataWidth-1 -: 8];
    assign hdr_rows_bad = (hdr_rows != 8'd0) && (int'(hdr_rows) != NumberOfRows);

    assign RowSelect       = WriteStrobe ? row_cnt : '1;
    assign LongFrameStrobe = (strobe_cnt != 4'd0);
    assign Synced          = (state != ST_UNSYNC);

`ifdef CONFIG_FSM_PARAM_WATCHDOG_EN
    localparam int                IDLE_W    = $clog2(WatchdogCycles + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(WatchdogCycles - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

    logic [IDLE_W-1:0] idle_cnt;

    assign wd_fire = (state == ST_DATA) && !WriteStrobe && (idle_cnt == IDLE_LAST);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            idle_cnt     <= '0;
            WatchdogTrip <= 1'b0;
        end else begin
            WatchdogTrip <= wd_fire;
            // Outside DATA the counter is held at zero, so entry to DATA starts clean.
            if (WriteStrobe || (state != ST_DATA) || wd_fire) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + IDLE_ONE;
            end
        end
    end
`else
    assign wd_fire      = 1'b0;
    assign WatchdogTrip = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state                <= ST_UNSYNC;
            row_cnt              <= '0;
            FrameAddressRegister <= '0;
            commit               <= 1'b0;
            strobe_cnt           <= '0;
            FrameCount           <= '0;
            HeaderError          <= 1'b0;
        end else begin
            commit <= 1'b0;

            // A fresh commit reloads the stretch counter, extending an active strobe.
            if (commit) begin
                strobe_cnt <= STROBE_LOAD;
            end else if (strobe_cnt != 4'd0) begin
                strobe_cnt <= strobe_cnt - 4'd1;
            end

            case (state)
                ST_UNSYNC: begin
                    if (WriteStrobe && (WriteData == SYNC_PATTERN)) begin
                        state <= ST_SYNCED;
                    end
                end
                ST_SYNCED: begin
                    if (WriteStrobe) begin
                        if (WriteData[DesyncFlag]) begin
                            state <= ST_UNSYNC;
                        end else begin
                            FrameAddressRegister <= WriteData[FrameBitsPerRow-1:0];
                            row_cnt              <= ROWS_LOAD;
                            state                <= ST_DATA;
                            if (hdr_rows_bad) begin
                                HeaderError <= 1'b1;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (wd_fire) begin
                        state   <= ST_UNSYNC;
                        row_cnt <= '0;
                    end else if (WriteStrobe) begin
                        if (row_cnt == ROW_LAST) begin
                            row_cnt    <= '0;
                            commit     <= 1'b1;
                            FrameCount <= FrameCount + FrameCountWidth'(1);
                            state      <= ST_SYNCED;
                        end else begin
                            row_cnt <= row_cnt - ROW_LAST;
                        end
                    end
                end
                default: begin
                    state <= ST_UNSYNC;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_config_fsm_param.sv
//------------------------------------------------------------------------------
// Module  : tb_config_fsm_param
// Purpose : Directed self-checking bench for config_fsm_param.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_config_fsm_param;

    logic        CLK;
    logic        Reset;
    logic [31:0] WriteData;
    logic        WriteStrobe;
    logic [31:0] FrameAddressRegister;
    logic        LongFrameStrobe;
    logic [4:0]  RowSelect;
    logic        Synced;
    logic [15:0] FrameCount;
    logic        HeaderError;
    logic        WatchdogTrip;

    // Second instance: single-row frames with a long strobe, for back-to-back commits.
    logic [31:0] wd2;
    logic        ws2;
    logic [31:0] far2;
    logic        lfs2;
    logic [4:0]  rs2;
    logic        sync2;
    logic [15:0] fc2;
    logic        herr2;
    logic        trip2;

    int total = 0;
    int bad   = 0;

    config_fsm_param #(
        .StrobeLength(2)
`ifdef CONFIG_FSM_PARAM_WATCHDOG_EN
        , .WatchdogCycles(16)
`endif
    ) dut (
        .CLK                 (CLK),
        .Reset               (Reset),
        .WriteData           (WriteData),
        .WriteStrobe         (WriteStrobe),
        .FrameAddressRegister(FrameAddressRegister),
        .LongFrameStrobe     (LongFrameStrobe),
        .RowSelect           (RowSelect),
        .Synced              (Synced),
        .FrameCount          (FrameCount),
        .HeaderError         (HeaderError),
        .WatchdogTrip        (WatchdogTrip)
    );

    config_fsm_param #(
        .NumberOfRows(1),
        .StrobeLength(4)
    ) dut2 (
        .CLK                 (CLK),
        .Reset               (Reset),
        .WriteData           (wd2),
        .WriteStrobe         (ws2),
        .FrameAddressRegister(far2),
        .LongFrameStrobe     (lfs2),
        .RowSelect           (rs2),
        .Synced              (sync2),
        .FrameCount          (fc2),
        .HeaderError         (herr2),
        .WatchdogTrip        (trip2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step(input logic ws, input logic [31:0] wd);
        WriteStrobe = ws;
        WriteData   = wd;
        @(posedge CLK);
        #1;
    endtask

    task automatic step2(input logic ws, input logic [31:0] wd);
        ws2 = ws;
        wd2 = wd;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        Reset = 1'b0;
        total++; if (Synced !== 1'b0) begin bad++; $display("FAIL reset_synced got=%b exp=0", Synced); end
        total++; if (FrameCount !== 16'd0) begin bad++; $display("FAIL reset_fc got=%0d exp=0", FrameCount); end
        total++; if (FrameAddressRegister !== 32'd0) begin bad++; $display("FAIL reset_far got=%h exp=0", FrameAddressRegister); end
        total++; if (LongFrameStrobe !== 1'b0) begin bad++; $display("FAIL reset_lfs got=%b exp=0", LongFrameStrobe); end
        total++; if (HeaderError !== 1'b0) begin bad++; $display("FAIL reset_herr got=%b exp=0", HeaderError); end
        total++; if (WatchdogTrip !== 1'b0) begin bad++; $display("FAIL reset_trip got=%b exp=0", WatchdogTrip); end
        total++; if (RowSelect !== 5'd31) begin bad++; $display("FAIL reset_rowsel got=%0d exp=31", RowSelect); end
    endtask

    task automatic test_sync;
        step(1'b1, 32'h1234_5678);
        total++; if (Synced !== 1'b0) begin bad++; $display("FAIL sync_noise got=%b exp=0", Synced); end
        step(1'b1, 32'hFAB0_FAB1);
        total++; if (Synced !== 1'b1) begin bad++; $display("FAIL sync_word got=%b exp=1", Synced); end
        step(1'b0, 32'h0);
        total++; if (RowSelect !== 5'd31) begin bad++; $display("FAIL sync_rowsel_idle got=%0d exp=31", RowSelect); end
    endtask

    task automatic test_full_frame;
        logic exp_lfs [3] = '{1'b1, 1'b1, 1'b0};
        WriteStrobe = 1'b1;
        WriteData   = 32'h0000_0005;
        #1;
        total++; if (RowSelect !== 5'd0) begin bad++; $display("FAIL ff_rowsel_hdr got=%0d exp=0", RowSelect); end
        @(posedge CLK); #1;
        total++; if (FrameAddressRegister !== 32'h5) begin bad++; $display("FAIL ff_far got=%h exp=5", FrameAddressRegister); end
        total++; if (HeaderError !== 1'b0) begin bad++; $display("FAIL ff_herr got=%b exp=0", HeaderError); end
        for (int i = 0; i < 10; i++) begin
            WriteStrobe = 1'b1;
            WriteData   = 32'hA000_0000 + i;
            #1;
            total++; if (RowSelect !== 5'(10 - i)) begin bad++; $display("FAIL ff_rowsel word=%0d got=%0d exp=%0d", i, RowSelect, 10 - i); end
            @(posedge CLK); #1;
        end
        total++; if (LongFrameStrobe !== 1'b0) begin bad++; $display("FAIL ff_lfs_early got=%b exp=0", LongFrameStrobe); end
        total++; if (FrameCount !== 16'd1) begin bad++; $display("FAIL ff_fc got=%0d exp=1", FrameCount); end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 32'h0);
            total++; if (LongFrameStrobe !== exp_lfs[k]) begin bad++; $display("FAIL ff_lfs cyc=%0d got=%b exp=%b", k, LongFrameStrobe, exp_lfs[k]); end
        end
        total++; if (Synced !== 1'b1) begin bad++; $display("FAIL ff_synced got=%b exp=1", Synced); end
    endtask

    task automatic test_desync;
        step(1'b1, 32'h0F10_0000);
        total++; if (Synced !== 1'b0) begin bad++; $display("FAIL desync_synced got=%b exp=0", Synced); end
        total++; if (FrameAddressRegister !== 32'h5) begin bad++; $display("FAIL desync_far got=%h exp=5", FrameAddressRegister); end
        total++; if (HeaderError !== 1'b0) begin bad++; $display("FAIL desync_herr got=%b exp=0", HeaderError); end
        step(1'b1, 32'hFAB0_FAB1);
        total++; if (Synced !== 1'b1) begin bad++; $display("FAIL desync_resync got=%b exp=1", Synced); end
        step(1'b0, 32'h0);
    endtask

    task automatic test_gapped;
        step(1'b1, 32'h0000_0007);
        total++; if (FrameAddressRegister !== 32'h7) begin bad++; $display("FAIL gap_far got=%h exp=7", FrameAddressRegister); end
        for (int i = 0; i < 10; i++) begin
            WriteStrobe = 1'b1;
            WriteData   = 32'h5500_0000 + i;
            #1;
            total++; if (RowSelect !== 5'(10 - i)) begin bad++; $display("FAIL gap_rowsel word=%0d got=%0d exp=%0d", i, RowSelect, 10 - i); end
            @(posedge CLK); #1;
            if (i < 9) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 32'h0);
                    total++; if (RowSelect !== 5'd31) begin bad++; $display("FAIL gap_rowsel_idle got=%0d exp=31", RowSelect); end
                end
            end
        end
        total++; if (FrameCount !== 16'd2) begin bad++; $display("FAIL gap_fc got=%0d exp=2", FrameCount); end
        for (int g = 0; g < 3; g++) step(1'b0, 32'h0);
    endtask

    task automatic test_back_to_back;
        logic exp_tail [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        step2(1'b1, 32'hFAB0_FAB1);
        step2(1'b1, 32'h0000_0044);
        ws2 = 1'b1;
        wd2 = 32'h1111_1111;
        #1;
        total++; if (rs2 !== 5'd1) begin bad++; $display("FAIL b2b_rowsel got=%0d exp=1", rs2); end
        @(posedge CLK); #1;
        total++; if (lfs2 !== 1'b0) begin bad++; $display("FAIL b2b_lfs_early got=%b exp=0", lfs2); end
        total++; if (fc2 !== 16'd1) begin bad++; $display("FAIL b2b_fc1 got=%0d exp=1", fc2); end
        step2(1'b1, 32'h0000_0045);
        total++; if (lfs2 !== 1'b1) begin bad++; $display("FAIL b2b_lfs_hdr2 got=%b exp=1", lfs2); end
        step2(1'b1, 32'h2222_2222);
        total++; if (lfs2 !== 1'b1) begin bad++; $display("FAIL b2b_lfs_data2 got=%b exp=1", lfs2); end
        total++; if (fc2 !== 16'd2) begin bad++; $display("FAIL b2b_fc2 got=%0d exp=2", fc2); end
        for (int k = 0; k < 5; k++) begin
            step2(1'b0, 32'h0);
            total++; if (lfs2 !== exp_tail[k]) begin bad++; $display("FAIL b2b_lfs_tail cyc=%0d got=%b exp=%b", k, lfs2, exp_tail[k]); end
        end
    endtask

    task automatic test_midframe_reset;
        step(1'b1, 32'h0000_0009);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h7700_0000 + i);
        Reset = 1'b1;
        step(1'b0, 32'h0);
        Reset = 1'b0;
        total++; if (Synced !== 1'b0) begin bad++; $display("FAIL mfr_synced got=%b exp=0", Synced); end
        total++; if (FrameCount !== 16'd0) begin bad++; $display("FAIL mfr_fc got=%0d exp=0", FrameCount); end
        total++; if (FrameAddressRegister !== 32'd0) begin bad++; $display("FAIL mfr_far got=%h exp=0", FrameAddressRegister); end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 32'h0);
            total++; if (LongFrameStrobe !== 1'b0) begin bad++; $display("FAIL mfr_lfs cyc=%0d got=%b exp=0", k, LongFrameStrobe); end
        end
    endtask

    task automatic test_header_error;
        step(1'b1, 32'hFAB0_FAB1);
        step(1'b1, 32'h0300_0000);
        total++; if (HeaderError !== 1'b1) begin bad++; $display("FAIL herr_flag got=%b exp=1", HeaderError); end
        for (int i = 0; i < 10; i++) begin
            WriteStrobe = 1'b1;
            WriteData   = 32'h3300_0000 + i;
            #1;
            total++; if (RowSelect !== 5'(10 - i)) begin bad++; $display("FAIL herr_rowsel word=%0d got=%0d exp=%0d", i, RowSelect, 10 - i); end
            @(posedge CLK); #1;
            if (i == 8) begin
                total++; if (FrameCount !== 16'd0) begin bad++; $display("FAIL herr_fc_word9 got=%0d exp=0", FrameCount); end
            end
        end
        total++; if (FrameCount !== 16'd1) begin bad++; $display("FAIL herr_fc got=%0d exp=1", FrameCount); end
        for (int g = 0; g < 3; g++) step(1'b0, 32'h0);
        total++; if (HeaderError !== 1'b1) begin bad++; $display("FAIL herr_sticky got=%b exp=1", HeaderError); end
    endtask

`ifdef CONFIG_FSM_PARAM_WATCHDOG_EN
    task automatic test_watchdog;
        step(1'b1, 32'h0000_0001);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h4400_0000 + i);
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 32'h0);
            if (k < 16) begin
                total++; if (WatchdogTrip !== 1'b0 || Synced !== 1'b1) begin bad++; $display("FAIL wd_early cyc=%0d trip=%b synced=%b exp trip=0 synced=1", k, WatchdogTrip, Synced); end
            end
        end
        total++; if (WatchdogTrip !== 1'b1) begin bad++; $display("FAIL wd_trip got=%b exp=1", WatchdogTrip); end
        total++; if (Synced !== 1'b0) begin bad++; $display("FAIL wd_synced got=%b exp=0", Synced); end
        step(1'b0, 32'h0);
        total++; if (WatchdogTrip !== 1'b0) begin bad++; $display("FAIL wd_pulse_len got=%b exp=0", WatchdogTrip); end
        total++; if (FrameCount !== 16'd1) begin bad++; $display("FAIL wd_fc got=%0d exp=1", FrameCount); end
        total++; if (LongFrameStrobe !== 1'b0) begin bad++; $display("FAIL wd_lfs got=%b exp=0", LongFrameStrobe); end
    endtask
`endif

    initial begin
        Reset       = 1'b1;
        WriteStrobe = 1'b0;
        WriteData   = 32'h0;
        ws2         = 1'b0;
        wd2         = 32'h0;
        @(posedge CLK); #1;

        test_reset();
        test_sync();
        test_full_frame();
        test_desync();
        test_gapped();
        test_back_to_back();
        test_midframe_reset();
        test_header_error();
`ifdef CONFIG_FSM_PARAM_WATCHDOG_EN
        test_watchdog();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
